// File: rtl/seq_alu.sv
// Purpose: multi-cycle ALU with Booth multiply and restoring divide, shared 5-bit opcode set.
// Latency: single-cycle ops done 1 cycle after accept; MUL/DIV done WIDTH+1 cycles after accept.
// Backpressure: start is accepted only in IDLE; busy stays high until done, starts meanwhile are dropped.
//
// Ports:
//   clock, clear        rising-edge clock, asynchronous active-low reset
//   start/op/ra/rb/branch  request; sampled only on an accepted start
//   busy, done          busy from the cycle after accept through done; done is a 1-cycle pulse
//   result_hi/lo        registered results, held until the next done
//   div_by_zero         updated with done; set only for DIV with rb == 0
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] rb,
    input  logic             branch,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int AW = SHW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_LOADI = 5'b00001;
    localparam logic [4:0] OP_STORE = 5'b00010;
    localparam logic [4:0] OP_ADD   = 5'b00011;
    localparam logic [4:0] OP_SUB   = 5'b00100;
    localparam logic [4:0] OP_AND   = 5'b00101;
    localparam logic [4:0] OP_OR    = 5'b00110;
    localparam logic [4:0] OP_ROR   = 5'b00111;
    localparam logic [4:0] OP_ROL   = 5'b01000;
    localparam logic [4:0] OP_SHR   = 5'b01001;
    localparam logic [4:0] OP_SHRA  = 5'b01010;
    localparam logic [4:0] OP_SHL   = 5'b01011;
    localparam logic [4:0] OP_ADDI  = 5'b01100;
    localparam logic [4:0] OP_ANDI  = 5'b01101;
    localparam logic [4:0] OP_ORI   = 5'b01110;
    localparam logic [4:0] OP_DIV   = 5'b01111;
    localparam logic [4:0] OP_MUL   = 5'b10000;
    localparam logic [4:0] OP_NEG   = 5'b10001;
    localparam logic [4:0] OP_NOT   = 5'b10010;
    localparam logic [4:0] OP_BR    = 5'b10011;
    localparam logic [4:0] OP_SHLA  = 5'b11111;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    // Work registers shared by both iterative ops:
    //   MUL: a_reg = Booth accumulator (one guard bit), q_reg = multiplier, b_reg = multiplicand
    //   DIV: a_reg[WIDTH-1:0] = partial remainder, q_reg = dividend/quotient, b_reg = |divisor|
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] b_reg;
    logic             q_m1;
    logic             neg_q;
    logic             neg_r;

    assign busy = (state != S_IDLE);
    assign done = (state == S_FIN);

    // ---------------- single-cycle datapath ----------------
    logic [SHW-1:0]   amt;
    logic [AW-1:0]    inv_amt;
    logic [WIDTH-1:0] sum_ab;
    logic [WIDTH-1:0] shl_v;
    logic [WIDTH-1:0] sra_v;
    logic [WIDTH-1:0] ror_v;
    logic [WIDTH-1:0] rol_v;
    logic [WIDTH-1:0] sc_hi;
    logic [WIDTH-1:0] sc_lo;

    assign amt     = rb[SHW-1:0];
    // Shifting by WIDTH yields zero, so rotate-by-0 degenerates cleanly to ra.
    assign inv_amt = AW'(WIDTH) - {1'b0, amt};
    assign sum_ab  = ra + rb;
    assign shl_v   = ra << amt;
    assign sra_v   = $signed(ra) >>> amt;
    assign ror_v   = (ra >> amt) | (ra << inv_amt);
    assign rol_v   = (ra << amt) | (ra >> inv_amt);

    always_comb begin
        sc_hi = '0;
        sc_lo = '0;
        case (op)
            OP_ADD, OP_ADDI, OP_LOAD, OP_LOADI, OP_STORE: sc_lo = sum_ab;
            OP_SUB:          sc_lo = ra - rb;
            OP_AND, OP_ANDI: sc_lo = ra & rb;
            OP_OR, OP_ORI:   sc_lo = ra | rb;
            OP_NEG:          sc_lo = -rb;
            OP_NOT:          sc_lo = ~rb;
            OP_SHR:          sc_lo = ra >> amt;
            OP_SHRA:         sc_lo = sra_v;
            OP_SHL:          sc_lo = shl_v;
            OP_SHLA:         sc_lo = {ra[WIDTH-1], shl_v[WIDTH-2:0]};
            OP_ROR:          sc_lo = ror_v;
            OP_ROL:          sc_lo = rol_v;
            OP_BR:           sc_lo = branch ? sum_ab : ra;
            // Only reaches the single-cycle path when rb == 0.
            OP_DIV: begin
                sc_lo = '1;
                sc_hi = ra;
            end
            default: begin
                sc_lo = '0;
                sc_hi = '0;
            end
        endcase
    end

    // ---------------- Booth step ----------------
    logic [WIDTH:0]   mcand_x;
    logic [WIDTH:0]   acc_sum;
    logic [WIDTH:0]   mul_a_nxt;
    logic [WIDTH-1:0] mul_q_nxt;

    assign mcand_x = {b_reg[WIDTH-1], b_reg};

    always_comb begin
        acc_sum = a_reg;
        case ({q_reg[0], q_m1})
            2'b01:   acc_sum = a_reg + mcand_x;
            2'b10:   acc_sum = a_reg - mcand_x;
            default: acc_sum = a_reg;
        endcase
    end

    // Arithmetic right shift of {acc, multiplier, q-1} by one.
    assign mul_a_nxt = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
    assign mul_q_nxt = {acc_sum[0], q_reg[WIDTH-1:1]};

    // ---------------- restoring divide step ----------------
    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] div_r_nxt;
    logic [WIDTH-1:0] div_q_nxt;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    // The remainder is always below the divisor magnitude (<= 2^(WIDTH-1)),
    // so its top bit is zero and can be dropped on the shift.
    assign rem_sh    = {a_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    assign diff      = {1'b0, rem_sh} - {1'b0, b_reg};
    assign div_r_nxt = diff[WIDTH] ? rem_sh : diff[WIDTH-1:0];
    assign div_q_nxt = {q_reg[WIDTH-2:0], ~diff[WIDTH]};

    // Most-negative maps to 2^(WIDTH-1), which is representable unsigned.
    assign abs_a = ra[WIDTH-1] ? -ra : ra;
    assign abs_b = rb[WIDTH-1] ? -rb : rb;

    // ---------------- control + state ----------------
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= S_IDLE;
            cnt         <= '0;
            a_reg       <= '0;
            q_reg       <= '0;
            b_reg       <= '0;
            q_m1        <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            result_hi   <= '0;
            result_lo   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            a_reg <= '0;
                            q_reg <= rb;
                            b_reg <= ra;
                            q_m1  <= 1'b0;
                            cnt   <= CW'(WIDTH);
                            state <= S_MUL;
                        end else if (op == OP_DIV && rb != '0) begin
                            a_reg <= '0;
                            q_reg <= abs_a;
                            b_reg <= abs_b;
                            neg_q <= ra[WIDTH-1] ^ rb[WIDTH-1];
                            neg_r <= ra[WIDTH-1];
                            cnt   <= CW'(WIDTH);
                            state <= S_DIV;
                        end else begin
                            result_hi   <= sc_hi;
                            result_lo   <= sc_lo;
                            div_by_zero <= (op == OP_DIV);
                            state       <= S_FIN;
                        end
                    end
                end
                S_MUL: begin
                    a_reg <= mul_a_nxt;
                    q_reg <= mul_q_nxt;
                    q_m1  <= q_reg[0];
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        result_hi   <= mul_a_nxt[WIDTH-1:0];
                        result_lo   <= mul_q_nxt;
                        div_by_zero <= 1'b0;
                        state       <= S_FIN;
                    end
                end
                S_DIV: begin
                    a_reg <= {1'b0, div_r_nxt};
                    q_reg <= div_q_nxt;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        result_lo   <= neg_q ? -div_q_nxt : div_q_nxt;
                        result_hi   <= neg_r ? -div_r_nxt : div_r_nxt;
                        div_by_zero <= 1'b0;
                        state       <= S_FIN;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

    localparam logic [4:0] OP_LOAD = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_SHLA = 5'b11111;
    localparam logic [4:0] OP_UND  = 5'b10100;

    logic        clk;
    logic        clear;

    logic        st32, br32;
    logic [4:0]  op32;
    logic [31:0] ra32, rb32;
    logic        busy32, dn32, dz32;
    logic [31:0] hi32, lo32;

    logic        st8, br8;
    logic [4:0]  op8;
    logic [7:0]  ra8, rb8;
    logic        busy8, dn8, dz8;
    logic [7:0]  hi8, lo8;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(32)) u_alu32 (
        .clock(clk), .clear(clear), .start(st32), .op(op32), .ra(ra32), .rb(rb32),
        .branch(br32), .busy(busy32), .done(dn32), .result_hi(hi32), .result_lo(lo32),
        .div_by_zero(dz32)
    );

    seq_alu #(.WIDTH(8)) u_alu8 (
        .clock(clk), .clear(clear), .start(st8), .op(op8), .ra(ra8), .rb(rb8),
        .branch(br8), .busy(busy8), .done(dn8), .result_hi(hi8), .result_lo(lo8),
        .div_by_zero(dz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          w8;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          br;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dz;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input bit w8, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit br, input logic [31:0] hi, input logic [31:0] lo, input bit dz,
                       input int lat);
        vec_t v;
        v.w8 = w8; v.op = op; v.a = a; v.b = b; v.br = br;
        v.hi = hi; v.lo = lo; v.dz = dz; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Issues one op (start for one cycle) and waits for done, bounded.
    // Returns at #1 after the edge that raised done; lat = cycles from accept edge.
    task automatic run_op(input bit w8, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit br, output logic [31:0] hi, output logic [31:0] lo,
                          output bit dz, output int lat);
        @(posedge clk); #1;
        if (w8) begin
            st8 = 1'b1; op8 = op; ra8 = a[7:0]; rb8 = b[7:0]; br8 = br;
        end else begin
            st32 = 1'b1; op32 = op; ra32 = a; rb32 = b; br32 = br;
        end
        @(posedge clk); #1;
        st8 = 1'b0;
        st32 = 1'b0;
        lat = 1;
        while (!(w8 ? dn8 : dn32) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        hi = w8 ? {24'h0, hi8} : hi32;
        lo = w8 ? {24'h0, lo8} : lo32;
        dz = w8 ? dz8 : dz32;
    endtask

    initial begin
        logic [31:0] hi, lo;
        bit          dz;
        int          lat;
        int          dcount;

        clear = 1'b0;
        st32 = 1'b0; op32 = '0; ra32 = '0; rb32 = '0; br32 = 1'b0;
        st8 = 1'b0; op8 = '0; ra8 = '0; rb8 = '0; br8 = 1'b0;

        // Single-cycle ops, WIDTH = 32
        add(0, OP_ADD,  32'hFFFFFFFF, 32'h00000002, 0, 32'h0, 32'h00000001, 0, 1);
        add(0, OP_SUB,  32'h00000005, 32'h00000007, 0, 32'h0, 32'hFFFFFFFE, 0, 1);
        add(0, OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h0, 32'hF000F000, 0, 1);
        add(0, OP_OR,   32'h0F0F0000, 32'h000000F0, 0, 32'h0, 32'h0F0F00F0, 0, 1);
        add(0, OP_ROR,  32'h00000001, 32'h00000001, 0, 32'h0, 32'h80000000, 0, 1);
        add(0, OP_ROL,  32'h80000001, 32'h00000004, 0, 32'h0, 32'h00000018, 0, 1);
        add(0, OP_ROR,  32'h12345678, 32'h00000020, 0, 32'h0, 32'h12345678, 0, 1);
        add(0, OP_SHR,  32'h80000000, 32'h0000001F, 0, 32'h0, 32'h00000001, 0, 1);
        add(0, OP_SHRA, 32'h80000000, 32'h00000004, 0, 32'h0, 32'hF8000000, 0, 1);
        add(0, OP_SHL,  32'h00000003, 32'h00000004, 0, 32'h0, 32'h00000030, 0, 1);
        add(0, OP_SHLA, 32'h40000001, 32'h00000001, 0, 32'h0, 32'h00000002, 0, 1);
        add(0, OP_SHLA, 32'h80000001, 32'h00000001, 0, 32'h0, 32'h80000002, 0, 1);
        add(0, OP_NEG,  32'h00000009, 32'h00000001, 0, 32'h0, 32'hFFFFFFFF, 0, 1);
        add(0, OP_NOT,  32'h00000000, 32'h0000FFFF, 0, 32'h0, 32'hFFFF0000, 0, 1);
        add(0, OP_BR,   32'h00000100, 32'h00000020, 1, 32'h0, 32'h00000120, 0, 1);
        add(0, OP_BR,   32'h00000100, 32'h00000020, 0, 32'h0, 32'h00000100, 0, 1);
        add(0, OP_LOAD, 32'h00000010, 32'h00000020, 0, 32'h0, 32'h00000030, 0, 1);
        add(0, OP_ADDI, 32'h7FFFFFFF, 32'h00000001, 0, 32'h0, 32'h80000000, 0, 1);
        add(0, OP_UND,  32'h12345678, 32'h11111111, 0, 32'h0, 32'h00000000, 0, 1);
        // Iterative ops, WIDTH = 32
        add(0, OP_MUL,  32'hFFFFFFFD, 32'h00000007, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 33);
        add(0, OP_MUL,  32'h80000000, 32'h80000000, 0, 32'h40000000, 32'h00000000, 0, 33);
        add(0, OP_MUL,  32'h00010000, 32'h00010000, 0, 32'h00000001, 32'h00000000, 0, 33);
        add(0, OP_DIV,  32'hFFFFFFF9, 32'h00000002, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 33);
        add(0, OP_DIV,  32'h80000000, 32'hFFFFFFFF, 0, 32'h00000000, 32'h80000000, 0, 33);
        add(0, OP_DIV,  32'h00000007, 32'hFFFFFFFE, 0, 32'h00000001, 32'hFFFFFFFD, 0, 33);
        add(0, OP_DIV,  32'h00000064, 32'h00000007, 0, 32'h00000002, 32'h0000000E, 0, 33);
        add(0, OP_DIV,  32'h00000005, 32'h00000000, 0, 32'h00000005, 32'hFFFFFFFF, 1, 1);
        add(0, OP_ADD,  32'h00000001, 32'h00000001, 0, 32'h0, 32'h00000002, 0, 1);
        // WIDTH = 8
        add(1, OP_MUL,  32'hFD, 32'h07, 0, 32'hFF, 32'hEB, 0, 9);
        add(1, OP_MUL,  32'h80, 32'h80, 0, 32'h40, 32'h00, 0, 9);
        add(1, OP_DIV,  32'hF9, 32'h02, 0, 32'hFF, 32'hFD, 0, 9);
        add(1, OP_DIV,  32'h80, 32'hFF, 0, 32'h00, 32'h80, 0, 9);
        add(1, OP_ADD,  32'hFF, 32'h02, 0, 32'h00, 32'h01, 0, 1);
        add(1, OP_ROR,  32'h01, 32'h01, 0, 32'h00, 32'h80, 0, 1);
        add(1, OP_DIV,  32'h05, 32'h00, 0, 32'h05, 32'hFF, 1, 1);
        add(1, OP_SUB,  32'h03, 32'h05, 0, 32'h00, 32'hFE, 0, 1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy32", {63'h0, busy32}, 64'h0);
        chk("rst_done32", {63'h0, dn32}, 64'h0);
        chk("rst_res32", {hi32, lo32}, 64'h0);
        chk("rst_dz32", {63'h0, dz32}, 64'h0);
        chk("rst_all8", {40'h0, busy8, dn8, dz8, 5'h0, hi8, lo8}, 64'h0);
        clear = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].w8, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].br, hi, lo, dz, lat);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("v%0d_lo", i), {32'h0, lo}, {32'h0, vecs[i].lo});
            chk($sformatf("v%0d_hi", i), {32'h0, hi}, {32'h0, vecs[i].hi});
            chk($sformatf("v%0d_dz", i), {63'h0, dz}, {63'h0, vecs[i].dz});
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_low", i), {63'h0, (vecs[i].w8 ? dn8 : dn32)}, 64'h0);
        end

        // In-flight immunity: scramble inputs and pulse start during a MUL.
        @(posedge clk); #1;
        st32 = 1'b1; op32 = OP_MUL; ra32 = 32'hFFFFFFFD; rb32 = 32'h00000007;
        @(posedge clk); #1;
        st32 = 1'b0;
        chk("imm_busy_k1", {63'h0, busy32}, 64'h1);
        lat = 1;
        while (!dn32 && lat < 100) begin
            ra32 = $urandom; rb32 = $urandom; op32 = OP_DIV; st32 = lat[0];
            @(posedge clk); #1;
            lat++;
        end
        chk("imm_lat", 64'(lat), 64'd33);
        chk("imm_res", {hi32, lo32}, 64'hFFFFFFFF_FFFFFFEB);
        chk("imm_busy_fin", {63'h0, busy32}, 64'h1);
        // A start during FIN must be ignored.
        st32 = 1'b1; op32 = OP_ADD; ra32 = 32'h1; rb32 = 32'h1;
        @(posedge clk); #1;
        st32 = 1'b0;
        chk("fin_start_done", {63'h0, dn32}, 64'h0);
        chk("fin_start_busy", {63'h0, busy32}, 64'h0);

        // Back-to-back: start held for 6 cycles -> 3 single-cycle ops.
        @(posedge clk); #1;
        st32 = 1'b1; op32 = OP_ADD; ra32 = 32'h10; rb32 = 32'h20;
        dcount = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (dn32) dcount++;
        end
        st32 = 1'b0;
        chk("b2b_count", 64'(dcount), 64'd3);
        chk("b2b_lo", {32'h0, lo32}, 64'h30);

        // Abort a MUL with clear at cycle 10 while scrambling inputs.
        @(posedge clk); #1;
        st32 = 1'b1; op32 = OP_MUL; ra32 = 32'hFFFFFFFD; rb32 = 32'h00000007;
        @(posedge clk); #1;
        for (int c = 1; c < 10; c++) begin
            op32 = c[0] ? OP_ADD : OP_DIV;
            ra32 = $urandom; rb32 = $urandom; st32 = c[0];
            @(posedge clk); #1;
        end
        st32 = 1'b0;
        chk("abort_busy_pre", {63'h0, busy32}, 64'h1);
        clear = 1'b0;
        #1;
        chk("abort_busy", {63'h0, busy32}, 64'h0);
        chk("abort_done", {63'h0, dn32}, 64'h0);
        chk("abort_res", {hi32, lo32}, 64'h0);
        chk("abort_dz", {63'h0, dz32}, 64'h0);
        @(posedge clk);
        @(posedge clk); #1;
        clear = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (dn32 || busy32) dcount++;
        end
        chk("abort_no_done", 64'(dcount), 64'd0);

        run_op(0, OP_ROR, 32'h00000001, 32'h00000001, 0, hi, lo, dz, lat);
        chk("post_ror_lat", 64'(lat), 64'd1);
        chk("post_ror_lo", {32'h0, lo}, 64'h80000000);
        chk("post_ror_hi", {32'h0, hi}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
